// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver (and reusable by uart_tx).
//   uart_state_t     : frame-level FSM states
//   DEF_CLKS_PER_BIT : default clk cycles per serial bit
//   DEF_BITS         : default data bits per frame
//   half_bit()       : mid-bit offset H = clks_per_bit / 2
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_t;

    localparam int DEF_CLKS_PER_BIT = 104;
    localparam int DEF_BITS         = 8;

    function automatic int half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle between uart_rx and its consumer.
//   rx_data   : received word, valid while rx_valid
//   rx_valid  : word available
//   rx_ready  : consumer accepts when rx_valid && rx_ready
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, a completed word was dropped
//   busy      : receiver is not idle
// master = uart_rx side, slave = consumer side.
interface uart_rx_if #(
    parameter int BITS = 8
);
    logic [BITS-1:0] rx_data;
    logic            rx_valid;
    logic            rx_ready;
    logic            frame_err;
    logic            overrun;
    logic            busy;

    modport master (
        output rx_data, rx_valid, frame_err, overrun, busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun, busy,
        output rx_ready
    );
endinterface

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset; both flops load RST_VAL
//   d_i   : asynchronous input
//   q_o   : synchronized output (2 cycles latency)
module bit_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: idle-high line, one start bit, BITS data bits LSB first,
// one stop bit. Samples at mid-bit and presents each good word on a
// one-entry valid/ready output register.
//   clk    : sole clock, rising edge
//   rst_n  : asynchronous active-low reset
//   i_data : serial input, asynchronous to clk
//   rx     : uart_rx_if master (rx_data/rx_valid/rx_ready/frame_err/overrun/busy)
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int BITS         = DEF_BITS
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_data,
    uart_rx_if.master rx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(BITS + 1);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(half_bit(CLKS_PER_BIT) - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(BITS - 1);

    logic            rxs;
    uart_state_t     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [BITS-1:0] shift_q, shift_d, shift_next;
    logic [BITS-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;
    logic            good_word;

    // Idle-high reset value so a quiet line is not mistaken for a start bit.
    bit_sync #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (i_data),
        .q_o   (rxs)
    );

    // New sample enters at the MSB and the word shifts right, so after BITS
    // samples the first received bit sits at bit 0.
    if (BITS == 1) begin : g_shift1
        assign shift_next = rxs;
    end else begin : g_shiftn
        assign shift_next = {rxs, shift_q[BITS-1:1]};
    end

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        good_word = 1'b0;
        ferr_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rxs) state_d = START;
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    // Line back high at mid-start: a glitch, not a frame.
                    state_d = rxs ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = shift_next;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        good_word = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            BREAK: begin
                // Wait out a held-low line so it cannot re-trigger a start.
                cnt_d = '0;
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register: a good word loads if the slot is empty or is being
    // drained on this same edge; otherwise the new word is dropped.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (good_word) begin
            if (!valid_q || rx.rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx.rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx.rx_data   = data_q;
    assign rx.rx_valid  = valid_q;
    assign rx.frame_err = ferr_q;
    assign rx.overrun   = ovr_q;
    assign rx.busy      = (state_q != IDLE);
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver, 8N1 by default, paired with the existing `uart_tx` transmitter on the same link format: idle-high line, one low start bit, BITS data bits LSB first, one high stop bit. It samples the asynchronous serial input at mid-bit, assembles the data word and presents it on a one-entry valid/ready output register. Error flags report framing errors and overruns. It sits between the board RX pin and the consuming logic, such as a command decoder or FIFO.

## Interface
- `clks_per_bit`, 104: clk cycles per serial bit; must be ≥ 4.
- `BITS`, 8: data bits per frame, 1..16.

- `clk` in 1: sole clock; all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_data` in 1: serial line, asynchronous to `clk`, idle high.
- `rx_data` out BITS: received word; valid while `rx_valid`.
- `rx_valid` out 1: word available.
- `rx_ready` in 1: consumer accepts the word when `rx_valid && rx_ready`.
- `frame_err` out 1: one-cycle pulse, stop bit sampled low.
- `overrun` out 1: one-cycle pulse, a completed word was dropped.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **Input synchronizer.** `i_data` passes through a 2-FF synchronizer. Both flops reset to 1. All FSM logic sees only the synchronized line `rxs`.
- **Counters.**
  - Bit-period counter width is `$clog2(clks_per_bit)`.
  - Define H = `clks_per_bit/2` (integer divide).
  - Bit index counter width is `$clog2(BITS+1)`.
- **FSM states:** IDLE, START, DATA, STOP, BREAK.
- **IDLE**
  - Counter is held at 0.
  - When `rxs==0`, go to START.
- **START**
  - Count to H-1.
  - At H-1: if `rxs==1`, the start was false; return to IDLE and produce no output. Otherwise clear the counter and go to DATA.
- **DATA**
  - Count to `clks_per_bit-1`.
  - At `clks_per_bit-1`, shift `rxs` into the shift register at the MSB, shifting right, so that bit 0 is the first bit received.
  - After BITS samples, go to STOP.
- **STOP**
  - Count to `clks_per_bit-1`, then sample.
  - If `rxs==1`: the word is good. Deliver it (see output register) and go to IDLE.
  - If `rxs==0`: pulse `frame_err`, discard the word and go to BREAK.
- **BREAK**
  - Stay until `rxs==1`, then go to IDLE. This prevents a held-low line from re-triggering.
- **Output register**
  - On a good-word cycle with `rx_valid==0`, or with `rx_valid && rx_ready` in that same cycle: load `rx_data` and set `rx_valid`.
  - On a good-word cycle with `rx_valid && !rx_ready`: keep the old word, pulse `overrun`, and drop the new word.
  - Otherwise, `rx_valid && rx_ready` clears `rx_valid`.
  - `rx_data` holds its value after acceptance.
- **Reset values:** `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, state IDLE, counters 0.
- **Reset mid-frame:** the partial word is lost and nothing is emitted. After release, the block requires `rxs==0` in IDLE to restart. A line held low across reset release is treated as a start.

## Timing
- Synchronizer latency: 2 cycles from the pin to `rxs`.
- Let t0 be the first cycle the FSM sees `rxs==0` in IDLE (the START entry cycle is t0+1). Sample points:
  - start check at t0+H;
  - data bit k (0-based) at t0+H+(k+1)·`clks_per_bit`;
  - stop bit at t0+H+(BITS+1)·`clks_per_bit`.
- `rx_valid`, `frame_err` and `overrun` change on the cycle after the stop sample.
- The FSM is back in IDLE on that same following cycle, leaving half a bit of margin before the next start edge.
- Back-to-back frames are supported with no idle gap between them.
- `rx_ready` may be tied high. Acceptance is combinational on `rx_valid && rx_ready` and takes effect at the next edge.
- No combinational path from `i_data` to any output.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE/START/DATA/STOP/BREAK), reusable by `uart_tx`;
  - the default `CLKS_PER_BIT` and `BITS` constants;
  - a function computing H.
- One sub-module, `bit_sync`: a 2-FF synchronizer with a reset-value parameter, instantiated with a reset value of 1.
- FSM, counters, shift register and output register live in `uart_rx`.

## Test plan
1. **Single word:** with `clks_per_bit`=16 and `rx_ready`=1, send frame 0xA5. → `rx_data`=0xA5 and a one-cycle `rx_valid`, exactly 8+(9·16)+1 cycles after start detection. No error flags.
2. **Glitch rejection:** drive `i_data` low for 5 cycles (less than H=8), then high. → FSM returns to IDLE; no `rx_valid`; `busy` is low again by cycle H+1.
3. **Framing error:** send 0x3C with the stop bit low, then hold low for 3 bit times, then send 0x81 normally. → one `frame_err` pulse, the FSM stays in BREAK while the line is low, and the next word 0x81 is received correctly.
4. **Overrun:** with `rx_ready`=0, send 0x11 then 0x22 back-to-back. → `rx_data` holds 0x11 and `overrun` pulses once at the end of the 0x22 frame. Raising `rx_ready` then clears `rx_valid`.
5. **Simultaneous accept and load:** assert `rx_ready` on exactly the cycle 0x22 completes while 0x11 is pending. → `rx_valid` stays high, `rx_data`=0x22, no `overrun`.
6. **Reset mid-frame:** pulse `rst_n` low during data bit 3 of 0xFF. → all outputs return to their reset values asynchronously; no word is emitted; the next full frame 0x5A is received correctly.
